mips32_regdump: RTL and testbench

Post-halt register-bank dump engine for the MIPS32 core. When the core raises HALTED, or on an explicit start pulse, it reads a contiguous window of the register bank through a synchronous read port. It streams each register out as an {index, value} beat on a valid/ready interface, so benches and debug links can read results without peeking hierarchically into RegBank.

---
 rtl/mips32_regdump.sv | 118 +++++++++++
 tb/tb_mips32_regdump.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_regdump.sv
// Post-halt register dump engine: reads a window of the register bank through a
// synchronous read port and streams {index, value} beats on a valid/ready link.
module mips32_regdump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 5
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_idx,
  input  logic [IDX_W:0]    count,
  output logic              rf_rd_en,
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_SEND, S_FIN} state_t;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W:0] ONE_CNT = (IDX_W+1)'(1);

  state_t              state_q, state_d;
  logic                halted_q;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [IDX_W:0]      rem_q, rem_d;
  logic [IDX_W-1:0]    addr_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                trig;
  logic [IDX_W:0]      count_clamped;

  assign trig          = start | (halted & ~halted_q);
  assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      cur_q    <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted;
      cur_q    <= cur_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      last_q   <= last_d;
      // Address only moves when a read is about to be issued, so it holds between reads.
      if (state_d == S_RD) addr_q <= cur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          cur_d   = start_idx;
          rem_d   = count_clamped;
          state_d = (count_clamped == '0) ? S_FIN : S_RD;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        data_d  = rf_rd_data;
        idx_d   = cur_q;
        last_d  = (rem_q == ONE_CNT);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          cur_d = cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rf_rd_en   = (state_q == S_RD);
    rf_rd_addr = addr_q;
    out_valid  = (state_q == S_SEND);
    out_idx    = idx_q;
    out_data   = data_q;
    out_last   = last_q;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FIN);
  end

endmodule

// File: tb/tb_mips32_regdump.sv
// Bench for mips32_regdump: a beat-queue model with cycle countdowns is checked
// against the DUT every cycle, plus literal expectations for each directed dump.
module tb_mips32_regdump;
  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        halted, start;
  logic [4:0]  start_idx;
  logic [5:0]  count;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last, busy, done;

  mips32_regdump #(.NUM_REGS(32), .DATA_W(32), .IDX_W(5)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .start(start),
    .start_idx(start_idx), .count(count),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] rf [32];
  initial rf_rd_data = '0;
  always @(posedge clk1) if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model state ----------------
  typedef struct { logic [4:0] idx; logic [31:0] data; } beat_t;
  beat_t q[$];
  int    cyc = 0;
  bit    model_idle = 1;
  bit    done_pending = 0;
  int    wait_cnt = 0;
  logic  halted_prev = 0;
  int    ndone = 0;
  int    busy_cyc = 0;
  int    trig_cyc = 0;
  bit    first_pending = 0;
  int    lat = -1;
  int    nlog = 0;
  int    log_idx [64];
  int    log_data[64];
  bit    prev_valid = 0, prev_hs = 0;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;
  logic        prev_last;
  int    ready_mode = 0;

  always @(posedge clk1) cyc++;

  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk1); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          ph = (ph + 1) % 3;
          out_ready = (ph != 0) && ($urandom_range(0, 3) != 0);
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk1) begin
    if (!rst_n) begin
      q.delete();
      model_idle = 1; done_pending = 0; wait_cnt = 0; halted_prev = 0;
      prev_valid = 0; prev_hs = 0; first_pending = 0;
    end else begin
      bit idle_at_start, exp_valid, exp_rd, hs;
      idle_at_start = model_idle;
      if (wait_cnt > 0) wait_cnt--;
      exp_valid = !model_idle && !done_pending && (q.size() > 0) && (wait_cnt == 0);
      exp_rd    = !model_idle && (q.size() > 0) && (wait_cnt == 2);
      chk("done", done, done_pending);
      chk("busy", busy, !model_idle);
      chk("out_valid", out_valid, exp_valid);
      chk("rf_rd_en", rf_rd_en, exp_rd);
      if (exp_rd) chk("rf_rd_addr", rf_rd_addr, q[0].idx);
      if (!out_valid) chk("out_last_idle", out_last, 1'b0);
      if (out_valid && prev_valid && !prev_hs) begin
        chk("stall_idx", out_idx, prev_idx);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (busy) busy_cyc++;
      if (out_valid && first_pending) begin
        lat = cyc - trig_cyc;
        first_pending = 0;
      end
      if (done_pending) begin
        done_pending = 0;
        model_idle = 1;
        ndone++;
      end
      hs = out_valid && out_ready;
      if (hs) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          bit is_last;
          is_last = (q.size() == 1);
          chk("beat_idx", out_idx, q[0].idx);
          chk("beat_data", out_data, q[0].data);
          chk("beat_last", out_last, is_last);
          if (nlog < 64) begin
            log_idx[nlog] = out_idx; log_data[nlog] = out_data;
          end
          nlog++;
          void'(q.pop_front());
          if (is_last) done_pending = 1; else wait_cnt = 3;
        end
      end
      if (idle_at_start && (start || (halted && !halted_prev))) begin
        int n;
        n = (count > 32) ? 32 : int'(count);
        for (int k = 0; k < n; k++) begin
          beat_t b;
          b.idx  = 5'((int'(start_idx) + k) % 32);
          b.data = rf[b.idx];
          q.push_back(b);
        end
        model_idle = 0;
        trig_cyc = cyc;
        if (n == 0) done_pending = 1;
        else begin wait_cnt = 3; first_pending = 1; end
      end
      halted_prev = halted;
      prev_valid = out_valid; prev_hs = hs;
      prev_idx = out_idx; prev_data = out_data; prev_last = out_last;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0;
    n0 = ndone;
    for (int k = 0; k < budget && ndone == n0; k++) @(posedge clk1);
    #1;
    chk(name, ndone > n0, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_beats(input string name, input int n, input int ei[6], input int ed[6]);
    chk({name, "_count"}, nlog, n);
    for (int k = 0; k < n && k < nlog; k++) begin
      chk({name, "_idx"}, log_idx[k], ei[k]);
      chk({name, "_data"}, log_data[k], ed[k]);
    end
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; halted = 1'b0; start = 1'b0; start_idx = '0; count = '0;
    for (int k = 0; k < 32; k++) rf[k] = '0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_en", rf_rd_en, 1'b0);
    chk("rst_rd_addr", rf_rd_addr, 5'd0);
    chk("rst_out", {out_idx, out_data, out_last}, 38'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // halted-edge dump of R0..R5 with ready held high
    rf[0] = 0; rf[1] = 10; rf[2] = 20; rf[3] = 25; rf[4] = 30; rf[5] = 55;
    start_idx = 5'd0; count = 6'd6; nlog = 0;
    halted = 1'b1;
    tick(1);
    wait_done("t1_done", 200);
    chk("t1_latency", lat, 3);
    check_beats("t1", 6, '{0,1,2,3,4,5}, '{0,10,20,25,30,55});
    tick(3);
    halted = 1'b0;
    tick(2);

    // same dump with stalls
    ready_mode = 1; nlog = 0;
    halted = 1'b1;
    tick(1);
    wait_done("t2_done", 400);
    check_beats("t2", 6, '{0,1,2,3,4,5}, '{0,10,20,25,30,55});
    halted = 1'b0; ready_mode = 0;
    tick(3);

    // wrap-around via start
    for (int k = 0; k < 32; k++) rf[k] = 32'(k * 3);
    start_idx = 5'd30; count = 6'd4; nlog = 0;
    pulse_start();
    wait_done("t3_done", 200);
    check_beats("t3", 4, '{30,31,0,1,0,0}, '{90,93,0,3,0,0});
    tick(2);

    // zero-length dump
    start_idx = 5'd7; count = 6'd0; nlog = 0; busy_cyc = 0;
    pulse_start();
    wait_done("t4_done", 20);
    tick(3);
    chk("t4_busy_cycles", busy_cyc, 1);
    chk("t4_beats", nlog, 0);

    // oversize count clamps to the whole bank
    start_idx = 5'd0; count = 6'd40; nlog = 0;
    pulse_start();
    wait_done("t4b_done", 400);
    chk("t4b_beats", nlog, 32);
    tick(2);

    // no retrigger while busy or on a held halted level
    start_idx = 5'd2; count = 6'd3; n0 = ndone;
    halted = 1'b1;
    tick(4);
    pulse_start();
    tick(45);
    chk("t5_single_dump", ndone - n0, 1);
    halted = 1'b0;
    tick(2);
    halted = 1'b1;
    tick(1);
    wait_done("t5_redump_done", 200);
    tick(20);
    chk("t5_two_dumps", ndone - n0, 2);
    halted = 1'b0;
    tick(2);

    // async reset while a beat is waiting
    ready_mode = 2; start_idx = 5'd9; count = 6'd1; nlog = 0;
    pulse_start();
    for (int k = 0; k < 10 && !out_valid; k++) tick(1);
    chk("t6_valid_before_rst", {out_valid, out_last}, 2'b11);
    @(posedge clk1); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_last", out_last, 1'b0);
    tick(2);
    rst_n = 1'b1; ready_mode = 0;
    tick(15);
    chk("t6_no_beats", nlog, 0);
    chk("t6_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
